// File: rtl/reg_arb8to1_if.sv
// rtl/reg_arb8to1_if.sv - handshake bundle between eight producers, the collector and the shared sink
interface reg_arb8to1_if #(
    parameter int DATA_BITS = 8
);
    logic [7:0]             in_valid;
    logic [8*DATA_BITS-1:0] in_data;
    logic [7:0]             in_ready;
    logic                   out_valid;
    logic [DATA_BITS-1:0]   out_data;
    logic [2:0]             out_src;
    logic                   out_ready;

    // Environment side: producers and sink.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    // Collector side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/reg_arb8to1.sv
// rtl/reg_arb8to1.sv - eight-source round-robin collector with a one-entry registered output
module reg_arb8to1 #(
    parameter int DATA_BITS = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    reg_arb8to1_if.slave bus
);
    logic                 out_valid_q, out_valid_d;
    logic [DATA_BITS-1:0] out_data_q,  out_data_d;
    logic [2:0]           out_src_q,   out_src_d;
    logic [2:0]           last_grant_q, last_grant_d;

    logic       can_accept;
    logic       found;
    logic [2:0] winner;
    logic [2:0] idx;
    logic [7:0] grant;
    logic       accept;
    logic       drain;

    assign can_accept = !out_valid_q || bus.out_ready;
    assign drain      = out_valid_q && bus.out_ready;

    // Search starts one past the last winner; offset 8 wraps back to last_grant itself.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        idx    = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = last_grant_q + k[2:0];
            if (!found && bus.in_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Gated by reset_n so in_ready drops the instant reset asserts.
    always_comb begin
        grant = 8'd0;
        if (reset_n && found && can_accept) begin
            grant[winner] = 1'b1;
        end
    end

    assign accept = |grant;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = bus.in_data[winner*DATA_BITS +: DATA_BITS];
            out_src_d    = winner;
            last_grant_d = winner;
        end else if (drain) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 3'd0;
            last_grant_q <= 3'd7;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: doc/reg_arb8to1.md
Name: reg_arb8to1

Overview:
- Eight-source to one-sink round-robin collector.
- Inverse of the 1-to-8 register demultiplexer: instead of routing one write onto eight destinations, it gathers eight independent producers onto one shared register/data bus.
- Valid/ready handshakes on both sides; one-entry registered output stage.
- Sits between execution/peripheral units and the shared result bus feeding the register file write port.

Parameters:
DATA_BITS, 8, width of each data word.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  8  in_valid[i] set: source i presents a word
in_data  input  8*DATA_BITS  source i word at in_data[i*DATA_BITS +: DATA_BITS]
in_ready  output  8  one-hot or zero; in_ready[i] set: source i word accepted this cycle
out_valid  output  1  output register holds a word
out_data  output  DATA_BITS  held word
out_src  output  3  index of the source that produced out_data
out_ready  input  1  sink accepts out_data this cycle

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer last_grant=7, so the first search starts at source 0.
  - in_ready=0 while reset_n is low.
- Handshakes:
  - Input transfer for source i occurs when in_valid[i] & in_ready[i] are both high at a clock edge.
  - Output transfer occurs when out_valid & out_ready are both high at a clock edge.
- Capacity:
  - can_accept = !out_valid | out_ready. The register is free, or it is being drained this same cycle.
- Grant (combinational):
  - Search in_valid starting at (last_grant+1) mod 8, ascending with wrap-around. The first set bit is the winner w.
  - in_ready = can_accept ? onehot(w) : 0.
  - No valid input gives in_ready=0.
  - in_ready never depends on in_data.
  - in_ready[i] is never set while in_valid[i]=0.
- On an input transfer from w (clock edge):
  - out_data <= word of w; out_src <= w; out_valid <= 1; last_grant <= w.
- On an output transfer with no input transfer in the same cycle:
  - out_valid <= 0.
  - out_data and out_src hold their values; they are don't-care when out_valid=0.
- Simultaneous output drain and new input accept:
  - The register is reloaded in the same cycle.
  - out_valid stays 1, so back-to-back throughput is one word per cycle.
- Output backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_src are stable and in_ready=0.
  - last_grant does not change without an input transfer.
- Latency:
  - A word accepted at edge N is visible on out_* after edge N.
  - Zero-cycle combinational path from out_ready to in_ready (deliberate; the sink must not combinationally depend on in_ready).
- Fairness:
  - With all 8 sources continuously valid and out_ready=1, grants cycle 0,1,...,7,0,...
  - No source waits more than 7 transfers.
- Sources are expected to hold in_valid/in_data stable until accepted. Dropping in_valid before acceptance is tolerated; the arbiter re-evaluates each cycle.
- Reset mid-transfer: the pending output word is discarded and the pointer returns to 7.
- No internal counters overflow: last_grant is 3 bits and wraps 7->0 by construction.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0 immediately. After release with in_valid=8'hFF -> first grant is source 0.
- Single source: in_valid=8'b0010_0000, in_data slot5=8'hA5, out_ready=1 -> in_ready=8'b0010_0000. Next cycle out_valid=1, out_data=8'hA5, out_src=5.
- Round-robin: all in_valid=1, slot i data=8'h10+i, out_ready=1 for 10 cycles -> out_src sequence 0,1,2,3,4,5,6,7,0,1 with matching data, one word per cycle.
- Backpressure: hold out_ready=0 after first accept of source 2 for 4 cycles -> in_ready=0, out_data/out_src stable, then out_ready=1 -> source 2 drained and source 3 accepted in the same edge.
- Wrap skip: last_grant=6, in_valid=8'b0100_0001 -> next grant is 0, not 6. Then with both still valid -> grant 6.
- Idle drain: one word pending, out_ready=1, in_valid=0 -> out_valid drops to 0 next cycle, in_ready stays 0.
